// File: rtl/mfcc_pkg.sv
// Shared MFCC front-end definitions: mel filterbank sizing, the filter
// sequencer state encoding and the band table entry layout.
package mfcc_pkg;

  localparam int unsigned NUM_FILTERS = 40;
  localparam int unsigned NUM_BINS    = 257;
  localparam int unsigned BIN_W       = $clog2(NUM_BINS);
  localparam int unsigned LEN_W       = $clog2(NUM_BINS + 1);
  localparam int unsigned COEF_AW     = 12;
  localparam int unsigned FILT_W      = $clog2(NUM_FILTERS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_ISSUE = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_e;

  // One mel band: first spectrum bin and number of bins (0 = empty band).
  typedef struct packed {
    logic [BIN_W-1:0] start;
    logic [LEN_W-1:0] len;
  } band_t;

endpackage

// File: rtl/mel_band_table.sv
// Per-filter band table: NUM_FILTERS entries of {start, len}, one write port,
// one registered read port, cleared on reset.
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   we, wr_addr    write strobe / entry index
//   wr_data        entry to store
//   rd_addr        entry to read (data appears the following cycle)
//   rd_data        registered read data
module mel_band_table
  import mfcc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [FILT_W-1:0] wr_addr,
  input  band_t             wr_data,
  input  logic [FILT_W-1:0] rd_addr,
  output band_t             rd_data
);

  band_t entries [NUM_FILTERS];

  // Write-first on a same-cycle address match, so a write issued together
  // with the read of the same entry is seen by that read.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_FILTERS; i++) begin
        entries[i] <= '0;
      end
      rd_data <= '0;
    end else begin
      if (we) begin
        entries[wr_addr] <= wr_data;
      end
      rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : entries[rd_addr];
    end
  end

endmodule

// File: rtl/mel_filter_sequencer.sv
// Mel filterbank MAC scheduler: walks every filter of the band table once
// per frame and issues one MAC op per bin (one zero-op for empty bands).
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   cfg_we/cfg_idx/cfg_start/cfg_len band table write (idle only)
//   cfg_err                          pulse after a rejected write
//   frame_start                      start one pass (ignored while busy)
//   busy, frame_done                 pass in progress / end-of-pass pulse
//   op_valid/op_ready                MAC op handshake
//   op_spec_addr, op_coef_addr       spectrum bin / coefficient ROM address
//   op_filt                          current filter index
//   op_first, op_last, op_zero       accumulator clear / emit / empty band
module mel_filter_sequencer
  import mfcc_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [FILT_W-1:0]  cfg_idx,
  input  logic [BIN_W-1:0]   cfg_start,
  input  logic [LEN_W-1:0]   cfg_len,
  output logic               cfg_err,
  input  logic               frame_start,
  output logic               busy,
  output logic               frame_done,
  output logic               op_valid,
  input  logic               op_ready,
  output logic [BIN_W-1:0]   op_spec_addr,
  output logic [COEF_AW-1:0] op_coef_addr,
  output logic [FILT_W-1:0]  op_filt,
  output logic               op_first,
  output logic               op_last,
  output logic               op_zero
);

  localparam int unsigned SUM_W = ((BIN_W > LEN_W) ? BIN_W : LEN_W) + 1;

  seq_state_e         state_q, state_d;
  logic [FILT_W-1:0]  filt_q, filt_d;
  logic [BIN_W-1:0]   bin_q, bin_d;
  logic [COEF_AW-1:0] coef_q, coef_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               valid_q, valid_d;
  logic               first_q, first_d;
  logic               last_q, last_d;
  logic               zero_q, zero_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  logic               tbl_we;
  logic [FILT_W-1:0]  rd_addr;
  band_t              wr_band;
  band_t              rd_band;
  logic               cfg_ok;

  assign wr_band.start = cfg_start;
  assign wr_band.len   = cfg_len;

  // Out-of-range filter indices are rejected like any other bad write.
  assign cfg_ok = (state_q == ST_IDLE)
               && (cfg_idx <= FILT_W'(NUM_FILTERS - 1))
               && ((SUM_W'(cfg_start) + SUM_W'(cfg_len)) <= SUM_W'(NUM_BINS));

  mel_band_table u_table (
    .clk     (clk),
    .rst     (rst),
    .we      (tbl_we),
    .wr_addr (cfg_idx),
    .wr_data (wr_band),
    .rd_addr (rd_addr),
    .rd_data (rd_band)
  );

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      filt_q  <= '0;
      bin_q   <= '0;
      coef_q  <= '0;
      rem_q   <= '0;
      valid_q <= 1'b0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      zero_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      filt_q  <= filt_d;
      bin_q   <= bin_d;
      coef_q  <= coef_d;
      rem_q   <= rem_d;
      valid_q <= valid_d;
      first_q <= first_d;
      last_q  <= last_d;
      zero_q  <= zero_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Next-state, table access and next output values.
  always_comb begin
    state_d = state_q;
    filt_d  = filt_q;
    bin_d   = bin_q;
    coef_d  = coef_q;
    rem_d   = rem_q;
    valid_d = valid_q;
    first_d = first_q;
    last_d  = last_q;
    zero_d  = zero_q;
    rd_addr = filt_q;
    tbl_we  = 1'b0;
    err_d   = 1'b0;

    if (cfg_we) begin
      if (cfg_ok) tbl_we = 1'b1;
      else        err_d  = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          state_d = ST_LOAD;
          filt_d  = '0;
          coef_d  = '0;
          rd_addr = '0;
        end
      end
      ST_LOAD: begin
        // rd_band holds the entry for filt_q, addressed on entry to LOAD.
        state_d = ST_ISSUE;
        bin_d   = rd_band.start;
        rem_d   = rd_band.len;
        zero_d  = (rd_band.len == '0);
        first_d = 1'b1;
        last_d  = (rd_band.len <= LEN_W'(1));
        valid_d = 1'b1;
      end
      ST_ISSUE: begin
        if (valid_q && op_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            first_d = 1'b0;
            last_d  = 1'b0;
            zero_d  = 1'b0;
            // An empty band consumes no coefficients.
            if (!zero_q) coef_d = coef_q + COEF_AW'(1);
            if (filt_q == FILT_W'(NUM_FILTERS - 1)) begin
              state_d = ST_DONE;
            end else begin
              filt_d  = filt_q + FILT_W'(1);
              rd_addr = filt_q + FILT_W'(1);
              state_d = ST_LOAD;
            end
          end else begin
            bin_d   = bin_q + BIN_W'(1);
            coef_d  = coef_q + COEF_AW'(1);
            rem_d   = rem_q - LEN_W'(1);
            first_d = 1'b0;
            last_d  = (rem_q == LEN_W'(2));
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  assign cfg_err      = err_q;
  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign op_valid     = valid_q;
  assign op_spec_addr = bin_q;
  assign op_coef_addr = coef_q;
  assign op_filt      = filt_q;
  assign op_first     = first_q;
  assign op_last      = last_q;
  assign op_zero      = zero_q;

endmodule

// File: doc/mel_filter_sequencer.md
# mel_filter_sequencer

Controller that schedules the mel filterbank multiply-accumulate for one spectral frame. It holds a per-filter band table (start bin, length) and walks all filters in order. For each bin of each filter it issues one MAC operation: a spectrum read address, a coefficient ROM address and first/last markers, over a valid/ready handshake. It sits between the periodogram buffer and the shared mel MAC, and the frame-level MFCC controller triggers it once per frame.

## Interface
Parameters:
- NUM_FILTERS, 40, number of mel filters per frame
- NUM_BINS, 257, number of periodogram bins in the spectrum buffer
- BIN_W, $clog2(NUM_BINS), spectrum address width
- LEN_W, $clog2(NUM_BINS+1), band length width
- COEF_AW, 12, coefficient ROM address width

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- cfg_we  in  1  band table write strobe
- cfg_idx  in  $clog2(NUM_FILTERS)  filter index to write
- cfg_start  in  BIN_W  first bin of the band
- cfg_len  in  LEN_W  number of bins in the band (0 allowed)
- cfg_err  out  1  one-cycle pulse when a config write is rejected
- frame_start  in  1  start one frame pass (pulse)
- busy  out  1  pass in progress
- frame_done  out  1  one-cycle pulse at end of pass
- op_valid  out  1  MAC operation available
- op_ready  in  1  MAC accepts the operation
- op_spec_addr  out  BIN_W  spectrum bin to read
- op_coef_addr  out  COEF_AW  coefficient ROM address
- op_filt  out  $clog2(NUM_FILTERS)  current filter index
- op_first  out  1  clear accumulator before this op
- op_last  out  1  emit the mel result after this op
- op_zero  out  1  empty band: MAC outputs 0 for this filter

## Operation
- States: IDLE, LOAD, ISSUE, DONE.
- IDLE: frame_start goes to LOAD with filt=0 and coef counter=0.
- LOAD: reads the band table for the current filt and sets bin=start and remaining=len. Goes to ISSUE.
- ISSUE: op_valid=1.
  - op_spec_addr=bin.
  - op_coef_addr=coef counter.
  - op_first is high on the first op of the filter.
  - op_last is high when remaining==1.
  - On handshake (op_valid&&op_ready): bin, coef counter and remaining each step by one.
  - On the last op: if filt==NUM_FILTERS-1, go to DONE; otherwise filt+1 and go to LOAD.
- len==0: exactly one op with first=last=zero=1, spec_addr=start, coef_addr=current counter. The coef counter does not advance. Every frame therefore yields exactly NUM_FILTERS MAC results.
- coef counter is cumulative over the frame, so filter m's coefficients start at the sum of the lengths of filters 0..m-1. It wraps modulo 2^COEF_AW.
- DONE: frame_done=1 for one cycle, then IDLE.
- Config writes:
  - Accepted only in IDLE.
  - Rejected with a cfg_err pulse (table unchanged) when busy, or when cfg_start+cfg_len > NUM_BINS.
- frame_start while busy is ignored; no error is raised.
- Simultaneous cfg_we and frame_start in IDLE: the write completes and the pass uses the new entry.

## Timing
- Reset values:
  - state=IDLE; busy=0; frame_done=0; cfg_err=0; op_valid=0.
  - All op_* outputs are 0.
  - Table entries are cleared to start=0, len=0.
- Cycle numbering, frame_start at cycle 0:
  - LOAD in cycle 1, busy=1 from cycle 1.
  - First op_valid in cycle 2.
- One LOAD bubble cycle between filters.
- With op_ready tied high, pass length = NUM_FILTERS + Σmax(len,1) + 1 (DONE) cycles after cycle 0.
- frame_done is asserted in the cycle after the last handshake. busy drops in the following cycle.
- While op_valid && !op_ready, all op_* outputs hold stable. op_valid never drops without a handshake, except on rst.
- Reset mid-pass: the next cycle is IDLE with op_valid=0 and no frame_done. The table is cleared.
- cfg_err pulses in the cycle after the rejected write.

## Structure
- Shared package mfcc_pkg holds:
  - NUM_FILTERS, NUM_BINS, BIN_W, LEN_W, COEF_AW.
  - The sequencer state enum.
  - The band entry struct {start, len}.
- Sub-module mel_band_table: NUM_FILTERS×(BIN_W+LEN_W) register file with one write port and one registered read port, cleared on rst. The LOAD cycle covers its read latency.

## Test plan
- Default table (all len=0), frame_start, op_ready=1 → 40 ops, each first=last=zero=1, coef_addr=0, filt 0..39; frame_done 81 cycles after frame_start.
- Program filter 0 (start=3, len=4) and filter 1 (start=5, len=2), rest len=0 → filter 0 spec_addr 3,4,5,6 / coef 0..3; filter 1 spec_addr 5,6 / coef 4,5, last on 6.
- Random op_ready backpressure → op_* stable while stalled; op sequence identical to the op_ready=1 run.
- cfg_we with start=250, len=10 → cfg_err pulse, entry unchanged. cfg_we while busy → cfg_err, no effect on the running pass.
- rst asserted mid-ISSUE → op_valid=0 and busy=0 the next cycle, no frame_done. A new frame_start with default table gives 40 zero-ops.
- frame_start repeated while busy → ignored; exactly one frame_done per accepted start.
